// File: rtl/triangle_setup_issuer_if.sv
// Vertex-in / triangle-out stream bundle for triangle_setup_issuer.
//   in_vtx/in_valid/in_ready        : vertex stream {y,x} into the issuer
//   out_v1..3/out_kind/out_valid/
//   out_ready                       : sorted triangle stream toward the rasterizer
// Modports:
//   slave  : the issuer's view (consumes vertices, produces triangles)
//   master : the environment's view (produces vertices, consumes triangles)
interface triangle_setup_issuer_if #(
  parameter int VW = 32
);
  logic [VW-1:0] in_vtx;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] out_v1;
  logic [VW-1:0] out_v2;
  logic [VW-1:0] out_v3;
  logic [1:0]    out_kind;
  logic          out_valid;
  logic          out_ready;

  modport slave (
    input  in_vtx, in_valid, out_ready,
    output in_ready, out_v1, out_v2, out_v3, out_kind, out_valid
  );

  modport master (
    output in_vtx, in_valid, out_ready,
    input  in_ready, out_v1, out_v2, out_v3, out_kind, out_valid
  );
endinterface

// File: rtl/triangle_setup_issuer.sv
// Upstream feeder for the triangle rasterizer. Gathers three screen-space
// vertices, sorts them by ascending y with a three-step stable compare-swap
// network, classifies the triangle and issues it over a valid/ready handshake.
// Ports:
//   clk       : system clock, rising edge
//   rst       : synchronous reset, active-high
//   bus       : triangle_setup_issuer_if.slave (vertex in / triangle out)
//   tri_count : triangles issued since reset, wraps at 2^CNTW
// Vertex word layout: {y[VW-1:CW], x[CW-1:0]}, coordinates unsigned.
// out_kind: 0=general, 1=flat-bottom, 2=flat-top, 3=degenerate.
module triangle_setup_issuer #(
  parameter int CW   = 16,
  parameter int VW   = 2 * CW,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  triangle_setup_issuer_if.slave bus,
  output logic [CNTW-1:0]      tri_count
);

  typedef enum logic [2:0] {
    S_COLLECT,
    S_SORT0,
    S_SORT1,
    S_SORT2,
    S_ISSUE
  } state_t;

  state_t          state;
  logic [1:0]      cnt;
  logic [VW-1:0]   slot [3];
  logic            pend;
  logic            in_ready_r;
  logic            out_valid_r;
  logic [VW-1:0]   v1_r;
  logic [VW-1:0]   v2_r;
  logic [VW-1:0]   v3_r;
  logic [1:0]      kind_r;
  logic [CNTW-1:0] count_r;
  logic            accept;

  function automatic logic [CW-1:0] y_of(input logic [VW-1:0] v);
    return v[VW-1:CW];
  endfunction

  // Priority matters: an all-equal triangle must report degenerate, not flat.
  function automatic logic [1:0] classify(input logic [CW-1:0] y1,
                                          input logic [CW-1:0] y2,
                                          input logic [CW-1:0] y3);
    if (y1 == y3) return 2'd3;
    if (y2 == y3) return 2'd1;
    if (y1 == y2) return 2'd2;
    return 2'd0;
  endfunction

  assign accept = (state == S_COLLECT) && in_ready_r && bus.in_valid;

  // Vertex slots: filled in arrival order, then sorted in place.
  // Strict '>' keeps equal-y vertices in arrival order.
  always_ff @(posedge clk) begin
    if (accept) begin
      slot[cnt] <= bus.in_vtx;
    end else if (state == S_SORT0 || state == S_SORT2) begin
      if (y_of(slot[0]) > y_of(slot[1])) begin
        slot[0] <= slot[1];
        slot[1] <= slot[0];
      end
    end else if (state == S_SORT1) begin
      if (y_of(slot[1]) > y_of(slot[2])) begin
        slot[1] <= slot[2];
        slot[2] <= slot[1];
      end
    end
  end

  // Control FSM. in_ready is registered so it reads 0 throughout reset and
  // rises the cycle after. ISSUE first spends one cycle loading the output
  // registers (pend), then waits for the rasterizer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_COLLECT;
      cnt         <= 2'd0;
      pend        <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      v1_r        <= '0;
      v2_r        <= '0;
      v3_r        <= '0;
      kind_r      <= 2'd0;
      count_r     <= '0;
    end else begin
      unique case (state)
        S_COLLECT: begin
          in_ready_r <= 1'b1;
          if (accept) begin
            if (cnt == 2'd2) begin
              cnt        <= 2'd0;
              in_ready_r <= 1'b0;
              state      <= S_SORT0;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        S_SORT0: state <= S_SORT1;
        S_SORT1: state <= S_SORT2;
        S_SORT2: begin
          pend  <= 1'b1;
          state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (pend) begin
            pend        <= 1'b0;
            v1_r        <= slot[0];
            v2_r        <= slot[1];
            v3_r        <= slot[2];
            kind_r      <= classify(y_of(slot[0]), y_of(slot[1]), y_of(slot[2]));
            out_valid_r <= 1'b1;
          end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
            count_r     <= count_r + {{(CNTW-1){1'b0}}, 1'b1};
            in_ready_r  <= 1'b1;
            state       <= S_COLLECT;
          end
        end
        default: begin
          state      <= S_COLLECT;
          cnt        <= 2'd0;
          pend       <= 1'b0;
          in_ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_v1    = v1_r;
  assign bus.out_v2    = v2_r;
  assign bus.out_v3    = v3_r;
  assign bus.out_kind  = kind_r;
  assign tri_count     = count_r;

endmodule
